// File: rtl/one_hot_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : one_hot_scanner_pkg
// Description : Shared state encodings and index-width derivation for the
//               one-hot scanner and its binary encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package one_hot_scanner_pkg;

  // Scanner state encodings, one bit is enough for two states
  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_SCAN = 1'b1;

  typedef enum logic [0:0] {
    IDLE = STATE_IDLE,
    SCAN = STATE_SCAN
  } state_e;

  // Width of a binary index able to address every bit of a word
  function automatic int index_width(input int word_width);
    return (word_width > 1) ? $clog2(word_width) : 1;
  endfunction

endpackage : one_hot_scanner_pkg
`default_nettype wire

// File: rtl/one_hot_scanner_one_hot_to_binary.sv
`default_nettype none
// ============================================================================
// Module      : one_hot_to_binary
// Description : Combinational one-hot to binary encoder. Each index bit is
//               the OR of all one-hot positions whose position number has
//               that bit set. Output is 0 for an all-zero input.
// Revision    : 1.0 - initial release
// ============================================================================
module one_hot_to_binary #(
  parameter int WORD_WIDTH  = 8,
  parameter int INDEX_WIDTH = 3
) (
  input  logic [WORD_WIDTH-1:0]  onehot_i,
  output logic [INDEX_WIDTH-1:0] index_o
);

  for (genvar b = 0; b < INDEX_WIDTH; b++) begin : g_index_bit
    logic w_or;

    // OR together every one-hot position whose binary position has bit b set
    always_comb begin
      w_or = 1'b0;
      for (int i = 0; i < WORD_WIDTH; i++) begin
        if (((i >> b) & 1) == 1) begin
          w_or = w_or | onehot_i[i];
        end
      end
    end

    assign index_o[b] = w_or;
  end : g_index_bit

endmodule : one_hot_to_binary
`default_nettype wire

// File: rtl/one_hot_scanner.sv
`default_nettype none
// ============================================================================
// Module      : one_hot_scanner
// Description : Accepts a bitvector and emits its set bits one at a time as
//               one-hot words, least-significant first, with binary index
//               and a last flag. All outputs decode from registered state.
// Revision    : 1.0 - initial release
// ============================================================================
module one_hot_scanner
  import one_hot_scanner_pkg::*;
#(
  parameter int   WORD_WIDTH  = 8,
  localparam int  INDEX_WIDTH = index_width(WORD_WIDTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   load_valid_i,
  output logic                   load_ready_o,
  input  logic [WORD_WIDTH-1:0]  bitvector_i,
  output logic                   empty_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [WORD_WIDTH-1:0]  onehot_o,
  output logic [INDEX_WIDTH-1:0] index_o,
  output logic                   last_o
);

  state_e                  state_q, state_d;
  logic [WORD_WIDTH-1:0]   pending_q, pending_d;
  logic                    empty_q, empty_d;

  logic [WORD_WIDTH-1:0]   w_onehot;
  logic [WORD_WIDTH-1:0]   w_remaining;
  logic [INDEX_WIDTH-1:0]  w_index;
  logic                    w_last;
  logic                    w_scanning;
  logic                    w_handshake;

  // Lowest set bit isolate; the wrap of the two's complement is intended and
  // pending is never zero while scanning, so the result is always one-hot
  assign w_onehot    = pending_q & (~pending_q + WORD_WIDTH'(1));
  assign w_remaining = pending_q & ~w_onehot;
  assign w_last      = (w_remaining == '0);
  assign w_scanning  = (state_q == SCAN);
  assign w_handshake = w_scanning & out_ready_i;

  one_hot_to_binary #(
    .WORD_WIDTH  (WORD_WIDTH),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_encoder (
    .onehot_i (w_onehot),
    .index_o  (w_index)
  );

  // Next-state: accept in IDLE, retire one bit per handshake in SCAN
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    empty_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid_i) begin
          if (bitvector_i != '0) begin
            pending_d = bitvector_i;
            state_d   = SCAN;
          end else begin
            empty_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (w_handshake) begin
          pending_d = w_remaining;
          if (w_last) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

  // State, pending set and empty pulse registers with asynchronous reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pending_q <= '0;
      empty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      empty_q   <= empty_d;
    end
  end

  // Outputs are forced to zero outside SCAN so nothing stale leaks out
  assign load_ready_o = (state_q == IDLE);
  assign out_valid_o  = w_scanning;
  assign empty_o      = empty_q;
  assign onehot_o     = w_scanning ? w_onehot : '0;
  assign index_o      = w_scanning ? w_index  : '0;
  assign last_o       = w_scanning & w_last;

endmodule : one_hot_scanner
`default_nettype wire

// File: tb/tb_one_hot_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_one_hot_scanner
// Description : Self-checking bench for one_hot_scanner (WORD_WIDTH = 8).
//               Expected outputs come from a list of set-bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_one_hot_scanner;

  localparam int W  = 8;
  localparam int IW = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          load_valid_i = 1'b0;
  logic          load_ready_o;
  logic [W-1:0]  bitvector_i = '0;
  logic          empty_o;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [W-1:0]  onehot_o;
  logic [IW-1:0] index_o;
  logic          last_o;

  int n_checks = 0;
  int n_fail   = 0;

  one_hot_scanner #(.WORD_WIDTH(W)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .bitvector_i  (bitvector_i),
    .empty_o      (empty_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .onehot_o     (onehot_o),
    .index_o      (index_o),
    .last_o       (last_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: always ready, 1: stall the first 3 cycles, 2: random ready
  task automatic run_vector(input logic [W-1:0] v, input int mode, input bit junk);
    int   q[$];
    int   pos;
    int   cyc;
    logic rdy;
    check("pre_load_ready", {31'd0, load_ready_o}, 32'd1);
    load_valid_i = 1'b1;
    bitvector_i  = v;
    @(negedge clk_i);
    if (junk) begin
      bitvector_i = ~v;
    end else begin
      load_valid_i = 1'b0;
      bitvector_i  = '0;
    end
    if (v == '0) begin
      check("empty_pulse", {31'd0, empty_o}, 32'd1);
      check("empty_no_valid", {31'd0, out_valid_o}, 32'd0);
      check("empty_ready", {31'd0, load_ready_o}, 32'd1);
      @(negedge clk_i);
      check("empty_one_cycle", {31'd0, empty_o}, 32'd0);
      check("empty_no_valid2", {31'd0, out_valid_o}, 32'd0);
      return;
    end
    for (int i = 0; i < W; i++) begin
      if (v[i]) q.push_back(i);
    end
    pos = 0;
    cyc = 0;
    while (pos < q.size()) begin
      check("out_valid", {31'd0, out_valid_o}, 32'd1);
      check("onehot", {24'd0, onehot_o}, 32'd1 << q[pos]);
      check("index", {29'd0, index_o}, q[pos]);
      check("last", {31'd0, last_o}, (pos == q.size() - 1) ? 32'd1 : 32'd0);
      check("busy_not_ready", {31'd0, load_ready_o}, 32'd0);
      check("no_empty_in_scan", {31'd0, empty_o}, 32'd0);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc >= 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (cyc > 40) rdy = 1'b1;
      out_ready_i = rdy;
      @(negedge clk_i);
      cyc++;
      if (rdy) pos++;
    end
    out_ready_i  = 1'b0;
    load_valid_i = 1'b0;
    bitvector_i  = '0;
    check("done_ready", {31'd0, load_ready_o}, 32'd1);
    check("done_valid", {31'd0, out_valid_o}, 32'd0);
    check("done_onehot", {24'd0, onehot_o}, 32'd0);
    check("done_index", {29'd0, index_o}, 32'd0);
    check("done_last", {31'd0, last_o}, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk_i);
    check("rst_ready", {31'd0, load_ready_o}, 32'd1);
    check("rst_valid", {31'd0, out_valid_o}, 32'd0);
    check("rst_empty", {31'd0, empty_o}, 32'd0);
    check("rst_onehot", {24'd0, onehot_o}, 32'd0);
    check("rst_index", {29'd0, index_o}, 32'd0);
    check("rst_last", {31'd0, last_o}, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Directed cases
    run_vector(8'hA4, 0, 1'b0);
    run_vector(8'hA4, 1, 1'b0);
    run_vector(8'h00, 0, 1'b0);
    run_vector(8'hFF, 0, 1'b0);
    run_vector(8'h01, 0, 1'b0);
    run_vector(8'h80, 1, 1'b0);
    run_vector(8'hF0, 0, 1'b1);

    // Reset in the middle of a scan of 8'h0C
    load_valid_i = 1'b1;
    bitvector_i  = 8'h0C;
    @(negedge clk_i);
    load_valid_i = 1'b0;
    bitvector_i  = '0;
    check("mid_first", {24'd0, onehot_o}, 32'h04);
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    check("mid_second", {24'd0, onehot_o}, 32'h08);
    #2 rst_ni = 1'b0;
    #1;
    check("async_valid", {31'd0, out_valid_o}, 32'd0);
    check("async_onehot", {24'd0, onehot_o}, 32'd0);
    check("async_ready", {31'd0, load_ready_o}, 32'd1);
    @(negedge clk_i);
    rst_ni      = 1'b1;
    out_ready_i = 1'b1;
    @(negedge clk_i);
    check("post_rst_valid", {31'd0, out_valid_o}, 32'd0);
    check("post_rst_onehot", {24'd0, onehot_o}, 32'd0);
    check("post_rst_ready", {31'd0, load_ready_o}, 32'd1);
    out_ready_i = 1'b0;

    // Random vectors with random backpressure and occasional junk loads
    for (int t = 0; t < 40; t++) begin
      run_vector(W'($urandom), 2, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_one_hot_scanner
`default_nettype wire
